// File: rtl/pauli_gate_pipe.sv
// Two-stage ready/valid pipeline applying a single-qubit Pauli gate (I/X/Y/Z)
// to a complex amplitude pair, with saturating negation and a sticky saturation flag.
module pauli_gate_pipe #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           gate_sel,
    input  logic [WIDTH-1:0]     a0_re,
    input  logic [WIDTH-1:0]     a0_im,
    input  logic [WIDTH-1:0]     a1_re,
    input  logic [WIDTH-1:0]     a1_im,
    output logic [WIDTH-1:0]     b0_re,
    output logic [WIDTH-1:0]     b0_im,
    output logic [WIDTH-1:0]     b1_re,
    output logic [WIDTH-1:0]     b1_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 sat_flag,
    input  logic                 sat_clr,
    output logic [CNT_WIDTH-1:0] op_count
);

    typedef enum logic [1:0] {
        GATE_I = 2'b00,
        GATE_X = 2'b01,
        GATE_Y = 2'b10,
        GATE_Z = 2'b11
    } gate_e;

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

    function automatic logic [WIDTH-1:0] sneg(input logic [WIDTH-1:0] x);
        return (x == MIN_VAL) ? MAX_VAL : (~x + 1'b1);
    endfunction

    logic                 s1_valid_q;
    gate_e                s1_gate_q;
    logic [WIDTH-1:0]     s1_a0re_q, s1_a0im_q, s1_a1re_q, s1_a1im_q;
    logic                 s2_valid_q;
    logic [WIDTH-1:0]     b0re_q, b0im_q, b1re_q, b1im_q;
    logic [WIDTH-1:0]     b0re_d, b0im_d, b1re_d, b1im_d;
    logic                 sat_d;
    logic                 sat_q, sat_flag_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 s1_adv, s2_adv, out_hs;

    // Stage 2 frees up when empty or draining; stage 1 when empty or stage 2 frees up.
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        in_ready   = s1_adv && !rst;
        out_hs     = s2_valid_q && out_ready;
        sat_flag_d = (s2_adv && s1_valid_q && sat_d) || (sat_q && !sat_clr);
    end

    always_comb begin
        b0re_d = s1_a0re_q;
        b0im_d = s1_a0im_q;
        b1re_d = s1_a1re_q;
        b1im_d = s1_a1im_q;
        sat_d  = 1'b0;
        case (s1_gate_q)
            GATE_I: ;
            GATE_X: begin
                b0re_d = s1_a1re_q;
                b0im_d = s1_a1im_q;
                b1re_d = s1_a0re_q;
                b1im_d = s1_a0im_q;
            end
            GATE_Y: begin
                b0re_d = s1_a1im_q;
                b0im_d = sneg(s1_a1re_q);
                b1re_d = sneg(s1_a0im_q);
                b1im_d = s1_a0re_q;
                sat_d  = (s1_a1re_q == MIN_VAL) || (s1_a0im_q == MIN_VAL);
            end
            GATE_Z: begin
                b1re_d = sneg(s1_a1re_q);
                b1im_d = sneg(s1_a1im_q);
                sat_d  = (s1_a1re_q == MIN_VAL) || (s1_a1im_q == MIN_VAL);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_gate_q  <= GATE_I;
            s1_a0re_q  <= '0;
            s1_a0im_q  <= '0;
            s1_a1re_q  <= '0;
            s1_a1im_q  <= '0;
        end else if (s1_adv) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_gate_q <= gate_e'(gate_sel);
                s1_a0re_q <= a0_re;
                s1_a0im_q <= a0_im;
                s1_a1re_q <= a1_re;
                s1_a1im_q <= a1_im;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            b0re_q     <= '0;
            b0im_q     <= '0;
            b1re_q     <= '0;
            b1im_q     <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                b0re_q <= b0re_d;
                b0im_q <= b0im_d;
                b1re_q <= b1re_d;
                b1im_q <= b1im_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sat_q <= sat_flag_d;
            if (out_hs) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign b0_re     = b0re_q;
    assign b0_im     = b0im_q;
    assign b1_re     = b1re_q;
    assign b1_im     = b1im_q;
    assign out_valid = s2_valid_q;
    assign sat_flag  = sat_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_pauli_gate_pipe.sv
// Bench for pauli_gate_pipe: directed and random traffic checked against an
// integer-arithmetic model of the Pauli gates held in an expected-result queue.
module tb_pauli_gate_pipe;

    localparam int W  = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, out_ready = 1'b0, sat_clr = 1'b0;
    logic          in_ready, out_valid, sat_flag;
    logic [1:0]    gate_sel = 2'b00;
    logic [W-1:0]  a0_re = '0, a0_im = '0, a1_re = '0, a1_im = '0;
    logic [W-1:0]  b0_re, b0_im, b1_re, b1_im;
    logic [CW-1:0] op_count;
    logic [63:0]   bvec;

    pauli_gate_pipe #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .gate_sel(gate_sel), .a0_re(a0_re), .a0_im(a0_im), .a1_re(a1_re), .a1_im(a1_im),
        .b0_re(b0_re), .b0_im(b0_im), .b1_re(b1_re), .b1_im(b1_im),
        .out_valid(out_valid), .out_ready(out_ready), .sat_flag(sat_flag),
        .sat_clr(sat_clr), .op_count(op_count)
    );

    always #5 clk = ~clk;
    assign bvec = {b0_re, b0_im, b1_re, b1_im};

    typedef struct packed {
        logic [63:0] b;
        logic        sat;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int unsigned cnt_m = 0;
    bit          sat_m = 0;
    bit          hold_pend = 0;
    logic [63:0] hold_b;
    int unsigned cyc = 0;

    function automatic int neg(input int x);
        int r = -x;
        if (r > 32767) r = 32767;
        return r;
    endfunction

    function automatic exp_t model(input logic [1:0] g, input logic [15:0] p0r, p0i, p1r, p1i);
        int   x0r = $signed(p0r);
        int   x0i = $signed(p0i);
        int   x1r = $signed(p1r);
        int   x1i = $signed(p1i);
        int   r0, r1, r2, r3;
        exp_t e;
        e.sat = 1'b0;
        case (g)
            2'd0: begin r0 = x0r; r1 = x0i; r2 = x1r; r3 = x1i; end
            2'd1: begin r0 = x1r; r1 = x1i; r2 = x0r; r3 = x0i; end
            2'd2: begin
                r0 = x1i; r1 = neg(x1r); r2 = neg(x0i); r3 = x0r;
                e.sat = (x1r == -32768) || (x0i == -32768);
            end
            default: begin
                r0 = x0r; r1 = x0i; r2 = neg(x1r); r3 = neg(x1i);
                e.sat = (x1r == -32768) || (x1i == -32768);
            end
        endcase
        e.b = {16'(r0), 16'(r1), 16'(r2), 16'(r3)};
        return e;
    endfunction

    function automatic logic [15:0] rnd16();
        return ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Called just after a falling edge with inputs driven; returns after the next one.
    task automatic cycle(output bit acc);
        exp_t e;
        #1;
        if (hold_pend) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", bvec, hold_b);
        end
        hold_pend = out_valid && !out_ready;
        hold_b    = bvec;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
            else begin
                e = exp_q.pop_front();
                check("result", bvec, e.b);
            end
            cnt_m = (cnt_m + 1) % 16;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            e = model(gate_sel, a0_re, a0_im, a1_re, a1_im);
            exp_q.push_back(e);
            sat_m |= e.sat;
        end
        cyc++;
        @(negedge clk);
        check("op_count", 64'(op_count), 64'(cnt_m));
    endtask

    task automatic idle(input int n);
        bit acc;
        in_valid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic send(input logic [1:0] g, input logic [15:0] p, q, r, s, input bit pat);
        bit acc;
        int n = 0;
        gate_sel = g; a0_re = p; a0_im = q; a1_re = r; a1_im = s;
        in_valid = 1'b1;
        do begin
            if (pat) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            cycle(acc);
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 40) begin
            cycle(acc);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("drained_valid", 64'(out_valid), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_op_count", 64'(op_count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_sat_flag", 64'(sat_flag), 64'd0);
        check("rst_b", bvec, 64'd0);
        exp_q.delete();
        cnt_m = 0; sat_m = 0; hold_pend = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Z gate: two-cycle latency and exact values
        out_ready = 1'b1;
        send(2'd3, 16'h1000, 16'h0200, 16'h0400, 16'hFF00, 0);
        check("lat_z_early", 64'(out_valid), 64'd0);
        idle(1);
        check("lat_z_valid", 64'(out_valid), 64'd1);
        check("z_value", bvec, 64'h1000_0200_FC00_0100);
        check("z_sat", 64'(sat_flag), 64'd0);
        idle(1);
        check("z_count", 64'(op_count), 64'd1);

        // Y gate
        send(2'd2, 16'd1, 16'd2, 16'd3, 16'd4, 0);
        idle(1);
        check("y_value", bvec, 64'h0004_FFFD_FFFE_0001);
        drain();

        // I and X with minimum values never saturate
        send(2'd0, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
        send(2'd1, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
        drain();
        check("ix_no_sat", 64'(sat_flag), 64'd0);

        // Saturating Z, sticky flag, then clear
        send(2'd3, 16'h0001, 16'h0002, 16'h8000, 16'h0005, 0);
        idle(1);
        check("sat_b1_re", 64'(b1_re), 64'h7FFF);
        check("sat_set", 64'(sat_flag), 64'd1);
        drain();
        idle(3);
        check("sat_sticky", 64'(sat_flag), 64'd1);
        sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
        check("sat_cleared", 64'(sat_flag), 64'd0);

        // Clear coinciding with a new saturation: set wins
        send(2'd3, 16'd0, 16'd0, 16'd0, 16'h8000, 0);
        sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
        check("sat_set_wins", 64'(sat_flag), 64'd1);
        drain();
        sat_clr = 1'b1; idle(1); sat_clr = 1'b0;
        check("sat_recleared", 64'(sat_flag), 64'd0);

        // Eight back-to-back I/X/Y/Z under a 1,0,0,1 ready pattern
        idle(1);
        do_reset();
        cyc = 0;
        for (int i = 0; i < 8; i++)
            send(2'(i % 4), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1);
        drain();
        check("burst_count", 64'(op_count), 64'd8);

        // Reset during a stall with two entries in flight
        out_ready = 1'b0;
        send(2'd1, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 0);
        send(2'd0, 16'h5555, 16'h6666, 16'h7777, 16'h0123, 0);
        idle(1);
        check("stall_full", 64'(in_ready), 64'd0);
        do_reset();
        out_ready = 1'b1;
        idle(5);
        check("no_stale", 64'(out_valid), 64'd0);

        // Counter wrap with a 4-bit counter
        for (int i = 0; i < 17; i++)
            send(2'd0, 16'(i), 16'(i), 16'(i), 16'(i), 0);
        drain();
        check("wrap_count", 64'(op_count), 64'd1);

        // Random traffic and stalls
        do_reset();
        for (int i = 0; i < 300; i++) begin
            bit acc;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (!hold_pend || 1) begin
                gate_sel = 2'($urandom);
                a0_re = rnd16(); a0_im = rnd16(); a1_re = rnd16(); a1_im = rnd16();
            end
            cycle(acc);
        end
        drain();
        check("rand_sat", 64'(sat_flag), 64'(sat_m));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
